// File: rtl/forward_ctrl.sv
// forward_ctrl: EX operand forwarding selects and load-use stall control for a 5-stage pipeline.
// Ports:
//   clk_i, rst_i                  clock and synchronous active-high reset
//   id_valid_i                    ID stage holds a real instruction
//   id_rs_i, id_rt_i              ID source register numbers
//   id_uses_rt_i                  ID instruction reads rt
//   id_dst_i                      ID destination register
//   id_regwrite_i, id_memread_i   ID writes a register / is a load
//   flush_i                       kill the instruction entering EX
//   fwd_a_sel_o, fwd_b_sel_o      00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_o                       hold PC and IF/ID this cycle
//   stall_count_o                 saturating count of stall cycles
module forward_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_uses_rt_i,
  input  logic [4:0]  id_dst_i,
  input  logic        id_regwrite_i,
  input  logic        id_memread_i,
  input  logic        flush_i,
  output logic [1:0]  fwd_a_sel_o,
  output logic [1:0]  fwd_b_sel_o,
  output logic        stall_o,
  output logic [15:0] stall_count_o
);
  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } stage_t;
  stage_t ex_q, mem_q, wb_q, ex_d, id_s;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  // MEM result wins over WB; register 0 is hardwired and never forwarded
  function automatic logic [1:0] fwd_sel(input stage_t ex, input stage_t mem, input stage_t wb, input logic [4:0] r);
    return !ex.valid ? 2'b00 :
           (mem.valid && mem.regwrite && mem.dst != 5'd0 && mem.dst == r) ? 2'b01 :
           (wb.valid && wb.regwrite && wb.dst != 5'd0 && wb.dst == r) ? 2'b10 : 2'b00;
  endfunction
  always_comb begin
    id_s = '{valid: id_valid_i, rs: id_rs_i, rt: id_rt_i, uses_rt: id_uses_rt_i,
             dst: id_dst_i, regwrite: id_regwrite_i, memread: id_memread_i};
    stall_o = id_valid_i && ex_q.valid && ex_q.memread && ex_q.dst != 5'd0 &&
              (ex_q.dst == id_rs_i || (id_uses_rt_i && ex_q.dst == id_rt_i)) && !flush_i;
    ex_d = (stall_o || flush_i) ? '0 : id_s;
    stall_cnt_d = (stall_o && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    fwd_a_sel_o = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs);
    fwd_b_sel_o = ex_q.uses_rt ? fwd_sel(ex_q, mem_q, wb_q, ex_q.rt) : 2'b00;
  end
  assign stall_count_o = stall_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule
